mp5_phantom_ctrl: RTL and testbench

Per-stage ingress controller for the mp5 stage FIFOs.
- Accepts one packet per cycle from the crossbar over a valid/ready handshake.
- Phantom packets: issues push, then records the returned slot address in an id->address map.
- Real packets matching a map entry: issues insert into the reserved slot, preserving timestamp order.
- All other packets: plain push. Drives the stage's push_in/insert_in/addr_in/fifo_id_in/pkt_in.

---
 rtl/mp5_pkg.sv | 40 ++++
 rtl/mp5_phantom_ctrl_if.sv | 33 +++
 rtl/mp5_addr_map.sv | 54 +++++
 rtl/mp5_phantom_ctrl.sv | 151 +++++++++++++++
 tb/tb_mp5_phantom_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mp5_pkg.sv
// Shared types and sizing for the mp5 stage ingress path.
package mp5_pkg;

  localparam int unsigned NUM_PIPELINES = 4;
  localparam int unsigned FIFO_SIZE     = 8;
  localparam int unsigned FIFO_ID_W     = $clog2(NUM_PIPELINES);
  localparam int unsigned ADDR_W        = $clog2(FIFO_SIZE);

  typedef struct packed {
    logic        phantom;
    logic [15:0] id;
    logic [15:0] ts;
    logic [7:0]  payload;
  } Packet;

  typedef struct packed {
    logic  valid;
    Packet pkt;
  } FIFO_Entry;

  typedef struct packed {
    Packet                pkt;
    logic [FIFO_ID_W-1:0] fifo_id;
  } Entry;

  // Reservation left behind by a phantom push: where its real twin must go.
  typedef struct packed {
    logic                 valid;
    logic [15:0]          tag;
    logic [FIFO_ID_W-1:0] fifo_id;
    logic [ADDR_W-1:0]    addr;
  } MapEntry;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/mp5_phantom_ctrl_if.sv
// Crossbar-to-controller handshake plus controller-to-stage command bus.
interface mp5_phantom_ctrl_if #(
  parameter int unsigned NUM_PIPELINES = mp5_pkg::NUM_PIPELINES,
  parameter int unsigned FIFO_SIZE     = mp5_pkg::FIFO_SIZE
);
  import mp5_pkg::*;

  logic                             in_valid;
  logic                             in_ready;
  Packet                            in_pkt;
  logic [$clog2(NUM_PIPELINES)-1:0] in_fifo_id;
  logic [NUM_PIPELINES-1:0]         full_in;
  logic [15:0]                      pkt_id_in;
  logic [$clog2(FIFO_SIZE)-1:0]     pkt_addr_in;
  logic                             push_out;
  logic                             insert_out;
  logic [$clog2(FIFO_SIZE)-1:0]     addr_out;
  logic [$clog2(NUM_PIPELINES)-1:0] fifo_id_out;
  Packet                            pkt_out;

  // Environment side: crossbar source and stage sink.
  modport master (
    output in_valid, in_pkt, in_fifo_id, full_in, pkt_id_in, pkt_addr_in,
    input  in_ready, push_out, insert_out, addr_out, fifo_id_out, pkt_out
  );

  // Controller side.
  modport slave (
    input  in_valid, in_pkt, in_fifo_id, full_in, pkt_id_in, pkt_addr_in,
    output in_ready, push_out, insert_out, addr_out, fifo_id_out, pkt_out
  );

endinterface

// File: rtl/mp5_addr_map.sv
// Direct-indexed id->slot map with one combinational read port and one
// write port; a write with valid=0 is a clear. Tracks the number of live entries.
module mp5_addr_map
  import mp5_pkg::*;
#(
  parameter int unsigned MAP_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(MAP_DEPTH)-1:0] i_ridx,
  output MapEntry                      o_rentry,
  input  logic                         i_we,
  input  logic [$clog2(MAP_DEPTH)-1:0] i_widx,
  input  MapEntry                      i_wentry,
  output logic [$clog2(MAP_DEPTH):0]   o_count
);

  localparam int unsigned IDX_W = $clog2(MAP_DEPTH);

  MapEntry          r_map [MAP_DEPTH];
  logic [IDX_W:0]   r_count;
  logic [IDX_W:0]   w_count_nxt;
  logic             w_old_valid;

  assign o_rentry    = r_map[i_ridx];
  assign o_count     = r_count;
  assign w_old_valid = r_map[i_widx].valid;

  // Count follows valid-bit transitions of the written entry.
  always_comb begin
    w_count_nxt = r_count;
    if (i_we && i_wentry.valid && !w_old_valid) begin
      w_count_nxt = r_count + (IDX_W+1)'(1);
    end else if (i_we && !i_wentry.valid && w_old_valid) begin
      w_count_nxt = r_count - (IDX_W+1)'(1);
    end
  end

  // Map storage and live-entry counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAP_DEPTH; i++) begin
        r_map[i] <= '0;
      end
      r_count <= '0;
    end else begin
      if (i_we) begin
        r_map[i_widx] <= i_wentry;
      end
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/mp5_phantom_ctrl.sv
// Per-stage ingress controller: phantoms reserve a FIFO slot via push and
// remember its address; the matching real packet is later inserted there.
module mp5_phantom_ctrl
  import mp5_pkg::*;
#(
  parameter int unsigned NUM_PIPELINES = mp5_pkg::NUM_PIPELINES,
  parameter int unsigned FIFO_SIZE     = mp5_pkg::FIFO_SIZE,
  parameter int unsigned MAP_DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  mp5_phantom_ctrl_if.slave          bus,
  output logic [$clog2(MAP_DEPTH):0] map_count,
  output logic                       err_id_mismatch
);

  localparam int unsigned IDX_W = $clog2(MAP_DEPTH);
  localparam int unsigned FID_W = $clog2(NUM_PIPELINES);
  localparam int unsigned AW    = $clog2(FIFO_SIZE);

  state_e           r_state, w_state_nxt;
  logic             r_push, w_push_nxt;
  logic             r_insert, w_insert_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic [FID_W-1:0] r_fifo_id, w_fifo_id_nxt;
  Packet            r_pkt, w_pkt_nxt;
  logic [15:0]      r_exp_id, w_exp_id_nxt;
  logic             r_err, w_err_nxt;

  logic [IDX_W-1:0] w_idx;
  MapEntry          w_rd;
  logic             w_hit;
  logic             w_full;
  logic             w_ready;
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  MapEntry          w_wentry;

  assign w_idx  = bus.in_pkt.id[IDX_W-1:0];
  assign w_hit  = w_rd.valid && (w_rd.tag == bus.in_pkt.id);
  assign w_full = bus.full_in[bus.in_fifo_id];

  mp5_addr_map #(
    .MAP_DEPTH(MAP_DEPTH)
  ) u_map (
    .clk      (clk),
    .rst      (rst),
    .i_ridx   (w_idx),
    .o_rentry (w_rd),
    .i_we     (w_we),
    .i_widx   (w_widx),
    .i_wentry (w_wentry),
    .o_count  (map_count)
  );

  // Next-state, ready, command and map-write decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_push_nxt    = 1'b0;
    w_insert_nxt  = 1'b0;
    w_addr_nxt    = r_addr;
    w_fifo_id_nxt = r_fifo_id;
    w_pkt_nxt     = r_pkt;
    w_exp_id_nxt  = r_exp_id;
    w_err_nxt     = r_err;
    w_ready       = 1'b0;
    w_we          = 1'b0;
    w_widx        = w_idx;
    w_wentry      = '0;
    case (r_state)
      ST_IDLE: begin
        // A phantom must not overwrite a live reservation; a hit needs no
        // free space because it fills an already reserved slot.
        if (bus.in_pkt.phantom) begin
          w_ready = !w_full && !w_rd.valid;
        end else if (w_hit) begin
          w_ready = 1'b1;
        end else begin
          w_ready = !w_full;
        end
        if (bus.in_valid && w_ready) begin
          w_pkt_nxt = bus.in_pkt;
          if (bus.in_pkt.phantom) begin
            w_push_nxt    = 1'b1;
            w_fifo_id_nxt = bus.in_fifo_id;
            w_exp_id_nxt  = bus.in_pkt.id;
            w_state_nxt   = ST_PUSH;
          end else if (w_hit) begin
            w_insert_nxt  = 1'b1;
            w_addr_nxt    = w_rd.addr;
            w_fifo_id_nxt = w_rd.fifo_id;
            w_we          = 1'b1;
          end else begin
            w_push_nxt    = 1'b1;
            w_fifo_id_nxt = bus.in_fifo_id;
          end
        end
      end
      ST_PUSH: begin
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_we             = 1'b1;
        w_widx           = r_exp_id[IDX_W-1:0];
        w_wentry.valid   = 1'b1;
        w_wentry.tag     = r_exp_id;
        w_wentry.fifo_id = r_fifo_id;
        w_wentry.addr    = bus.pkt_addr_in;
        if (bus.pkt_id_in != r_exp_id) begin
          w_err_nxt = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_push    <= 1'b0;
      r_insert  <= 1'b0;
      r_addr    <= '0;
      r_fifo_id <= '0;
      r_pkt     <= '0;
      r_exp_id  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_push    <= w_push_nxt;
      r_insert  <= w_insert_nxt;
      r_addr    <= w_addr_nxt;
      r_fifo_id <= w_fifo_id_nxt;
      r_pkt     <= w_pkt_nxt;
      r_exp_id  <= w_exp_id_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.push_out    = r_push;
  assign bus.insert_out  = r_insert;
  assign bus.addr_out    = r_addr;
  assign bus.fifo_id_out = r_fifo_id;
  assign bus.pkt_out     = r_pkt;
  assign err_id_mismatch = r_err;

endmodule

// File: tb/tb_mp5_phantom_ctrl.sv
// Scoreboard bench for mp5_phantom_ctrl: the driver queues the expected stage
// command on each accept, the monitor checks every push/insert pulse.
module tb_mp5_phantom_ctrl;
  import mp5_pkg::*;

  typedef struct packed {
    logic        push;
    logic        insert;
    logic [2:0]  addr;
    logic [1:0]  fid;
    Packet       pkt;
  } cmd_t;

  logic       clk;
  logic       rst;
  logic [4:0] map_count;
  logic       err;

  int   n_pass  = 0;
  int   n_total = 0;
  int   waited;
  cmd_t q[$];

  mp5_phantom_ctrl_if bus ();

  mp5_phantom_ctrl #(
    .NUM_PIPELINES(4),
    .FIFO_SIZE    (8),
    .MAP_DEPTH    (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .map_count      (map_count),
    .err_id_mismatch(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic Packet mk(input logic ph, input logic [15:0] id);
    Packet p;
    p.phantom = ph;
    p.id      = id;
    p.ts      = id + 16'h0100;
    p.payload = id[7:0] ^ 8'h5A;
    return p;
  endfunction

  function automatic cmd_t ex_push(input logic ph, input logic [15:0] id, input logic [1:0] fid);
    cmd_t c;
    c.push   = 1'b1;
    c.insert = 1'b0;
    c.addr   = 3'd0;
    c.fid    = fid;
    c.pkt    = mk(ph, id);
    return c;
  endfunction

  function automatic cmd_t ex_ins(input logic [15:0] id, input logic [2:0] addr, input logic [1:0] fid);
    cmd_t c;
    c.push   = 1'b0;
    c.insert = 1'b1;
    c.addr   = addr;
    c.fid    = fid;
    c.pkt    = mk(1'b0, id);
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_pkt     = mk(1'b0, 16'h0000);
    bus.in_fifo_id = 2'd0;
  endtask

  // Present a packet until accepted (bounded), queue its expected command.
  task automatic send(input logic ph, input logic [15:0] id, input logic [1:0] fid,
                      input cmd_t exp, output int w);
    bus.in_valid   = 1'b1;
    bus.in_pkt     = mk(ph, id);
    bus.in_fifo_id = fid;
    w = 0;
    #1;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!bus.in_ready) begin
      n_total++;
      $display("FAIL accept_timeout: id 0x%0h not accepted within %0d cycles", id, w);
      idle_inputs();
      return;
    end
    q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_idle();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every command pulse must match the oldest queued expectation.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (bus.push_out === 1'b1 || bus.insert_out === 1'b1) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_cmd: push=%0b insert=%0b with nothing expected",
                   bus.push_out, bus.insert_out);
        end else begin
          e = q.pop_front();
          chk("cmd_push", 64'(bus.push_out), 64'(e.push));
          chk("cmd_insert", 64'(bus.insert_out), 64'(e.insert));
          chk("cmd_fifo_id", 64'(bus.fifo_id_out), 64'(e.fid));
          chk("cmd_pkt", 64'(bus.pkt_out), 64'(e.pkt));
          if (e.insert) chk("cmd_addr", 64'(bus.addr_out), 64'(e.addr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.full_in     = 4'b0000;
    bus.pkt_id_in   = 16'h0000;
    bus.pkt_addr_in = 3'd0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_push", 64'(bus.push_out), 64'd0);
    chk("rst_insert", 64'(bus.insert_out), 64'd0);
    chk("rst_map_count", 64'(map_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    // Plain push into an empty map.
    send(1'b0, 16'h0005, 2'd2, ex_push(1'b0, 16'h0005, 2'd2), waited);
    #1;
    chk("plain_map_count", 64'(map_count), 64'd0);

    // Phantom reserves slot 6 in fifo 1, then its real twin is inserted there.
    bus.pkt_id_in   = 16'h0013;
    bus.pkt_addr_in = 3'd6;
    send(1'b1, 16'h0013, 2'd1, ex_push(1'b1, 16'h0013, 2'd1), waited);
    #1;
    chk("phantom_ready_push", 64'(bus.in_ready), 64'd0);
    @(negedge clk); #1;
    chk("phantom_ready_capture", 64'(bus.in_ready), 64'd0);
    @(negedge clk); #1;
    chk("phantom_ready_back", 64'(bus.in_ready), 64'd1);
    chk("phantom_map_count", 64'(map_count), 64'd1);
    send(1'b0, 16'h0013, 2'd3, ex_ins(16'h0013, 3'd6, 2'd1), waited);
    #1;
    chk("insert_map_count", 64'(map_count), 64'd0);
    chk("insert_err", 64'(err), 64'd0);

    // Full backpressure on a miss, then a hit accepted despite full.
    bus.full_in    = 4'b0001;
    bus.in_valid   = 1'b1;
    bus.in_pkt     = mk(1'b0, 16'h0020);
    bus.in_fifo_id = 2'd0;
    #1;
    chk("full_stall_0", 64'(bus.in_ready), 64'd0);
    @(negedge clk); #1;
    chk("full_stall_1", 64'(bus.in_ready), 64'd0);
    bus.full_in = 4'b0000;
    send(1'b0, 16'h0020, 2'd0, ex_push(1'b0, 16'h0020, 2'd0), waited);
    chk("full_release_wait", 64'(waited), 64'd0);
    bus.pkt_id_in   = 16'h0007;
    bus.pkt_addr_in = 3'd2;
    send(1'b1, 16'h0007, 2'd0, ex_push(1'b1, 16'h0007, 2'd0), waited);
    wait_idle();
    bus.full_in = 4'b0001;
    send(1'b0, 16'h0007, 2'd0, ex_ins(16'h0007, 3'd2, 2'd0), waited);
    chk("hit_under_full_wait", 64'(waited), 64'd0);
    bus.full_in = 4'b0000;

    // Collision on idx 3, released by the resident's insert; the new
    // phantom's report carries a wrong id.
    bus.pkt_id_in   = 16'h0003;
    bus.pkt_addr_in = 3'd4;
    send(1'b1, 16'h0003, 2'd2, ex_push(1'b1, 16'h0003, 2'd2), waited);
    wait_idle();
    #1;
    chk("resident_map_count", 64'(map_count), 64'd1);
    bus.pkt_id_in   = 16'h0099;
    bus.pkt_addr_in = 3'd5;
    bus.in_valid    = 1'b1;
    bus.in_pkt      = mk(1'b1, 16'h0013);
    bus.in_fifo_id  = 2'd1;
    #1;
    chk("collision_stall_0", 64'(bus.in_ready), 64'd0);
    @(negedge clk); #1;
    chk("collision_stall_1", 64'(bus.in_ready), 64'd0);
    send(1'b0, 16'h0003, 2'd0, ex_ins(16'h0003, 3'd4, 2'd2), waited);
    send(1'b1, 16'h0013, 2'd1, ex_push(1'b1, 16'h0013, 2'd1), waited);
    chk("collision_release_wait", 64'(waited), 64'd0);
    wait_idle();
    #1;
    chk("mismatch_err", 64'(err), 64'd1);
    chk("mismatch_map_count", 64'(map_count), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("mismatch_err_sticky", 64'(err), 64'd1);
    send(1'b0, 16'h0013, 2'd0, ex_ins(16'h0013, 3'd5, 2'd1), waited);
    #1;
    chk("mismatch_entry_cleared", 64'(map_count), 64'd0);
    chk("mismatch_err_sticky2", 64'(err), 64'd1);

    // Reset while the phantom push is in flight.
    bus.pkt_id_in   = 16'h002A;
    bus.pkt_addr_in = 3'd7;
    send(1'b1, 16'h002A, 2'd3, ex_push(1'b1, 16'h002A, 2'd3), waited);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_map_count", 64'(map_count), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_push", 64'(bus.push_out), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_write", 64'(map_count), 64'd0);
    send(1'b0, 16'h002A, 2'd3, ex_push(1'b0, 16'h002A, 2'd3), waited);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
